// File: rtl/prbs_pkg.sv
// Shared constants and types for the XNOR-feedback dither PRBS generator.
package prbs_pkg;

   localparam int unsigned LFSR_LEN = 15;
   localparam int unsigned TAP_A    = 14;
   localparam int unsigned TAP_B    = 13;

   typedef logic [LFSR_LEN-1:0] lfsr_state_t;

   // All-ones is the one state an XNOR LFSR can never leave.
   localparam lfsr_state_t LOCKUP_STATE = 15'h7FFF;
   localparam lfsr_state_t SEED_RESET   = 15'h0000;

endpackage

// File: rtl/lfsr_xnor_step.sv
// Combinational W_OUT-step unroll of the x^15 + x^14 + 1 XNOR LFSR.
module lfsr_xnor_step
   import prbs_pkg::*;
#(
   parameter int unsigned W_OUT = 4
) (
   input  logic [LFSR_LEN-1:0] state_cur,
   output logic [LFSR_LEN-1:0] state_nxt,
   output logic [W_OUT-1:0]    word
);

   logic [LFSR_LEN-1:0] s;
   logic                fb;

   // First-generated bit lands in the MSB of the word.
   always_comb begin
      s    = state_cur;
      fb   = 1'b0;
      word = '0;
      for (int unsigned i = 0; i < W_OUT; i++) begin
         fb                = ~(s[TAP_A] ^ s[TAP_B]);
         word[W_OUT-1-i]   = fb;
         s                 = {s[LFSR_LEN-2:0], fb};
      end
      state_nxt = s;
   end

endmodule

// File: rtl/dither_prbs_gen.sv
// Word-parallel PRBS dither source with valid/ready output, seed load,
// lock-up seed protection and a transfer counter.
module dither_prbs_gen
   import prbs_pkg::*;
#(
   parameter int unsigned W_OUT = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                seed_ld,
   input  logic [LFSR_LEN-1:0] seed,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [W_OUT-1:0]    out_data,
   output logic                lockup_err,
   output logic [CNT_W-1:0]    word_cnt
);

   lfsr_state_t         state_q, state_d;
   lfsr_state_t         step_state;
   logic [W_OUT-1:0]    step_word;
   logic [W_OUT-1:0]    data_d;
   logic                valid_d;
   logic                lockup_d;
   logic [CNT_W-1:0]    cnt_d;
   logic                xfer;
   logic                load;

   lfsr_xnor_step #(.W_OUT(W_OUT)) u_step (
      .state_cur (state_q),
      .state_nxt (step_state),
      .word      (step_word)
   );

   assign xfer = out_valid && out_ready;
   assign load = en && (!out_valid || out_ready);

   // Next-state: seed load overrides generation; a stalled word is held.
   always_comb begin
      state_d  = state_q;
      data_d   = out_data;
      valid_d  = out_valid;
      lockup_d = 1'b0;
      cnt_d    = word_cnt;
      if (xfer) begin
         cnt_d = word_cnt + CNT_W'(1);
      end
      if (seed_ld) begin
         valid_d = 1'b0;
         if (seed == LOCKUP_STATE) begin
            state_d  = SEED_RESET;
            lockup_d = 1'b1;
         end else begin
            state_d = seed;
         end
      end else if (load) begin
         state_d = step_state;
         data_d  = step_word;
         valid_d = 1'b1;
      end else if (xfer) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= SEED_RESET;
         out_data   <= '0;
         out_valid  <= 1'b0;
         lockup_err <= 1'b0;
         word_cnt   <= '0;
      end else begin
         state_q    <= state_d;
         out_data   <= data_d;
         out_valid  <= valid_d;
         lockup_err <= lockup_d;
         word_cnt   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_dither_prbs_gen.sv
// Directed self-checking bench for dither_prbs_gen (W_OUT=4, plus a CNT_W=4 copy).
module tb_dither_prbs_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        seed_ld = 1'b0;
   logic [14:0] seed = 15'h0000;
   logic        out_ready = 1'b0;
   logic        out_valid, out_valid4;
   logic [3:0]  out_data, out_data4;
   logic        lockup_err, lockup_err4;
   logic [15:0] word_cnt;
   logic [3:0]  word_cnt4;

   int pass_cnt = 0;
   int total_cnt = 0;
   int lockup_hits = 0;

   dither_prbs_gen #(.W_OUT(4), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .en(en), .seed_ld(seed_ld), .seed(seed),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .lockup_err(lockup_err), .word_cnt(word_cnt)
   );

   dither_prbs_gen #(.W_OUT(4), .CNT_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .en(en), .seed_ld(seed_ld), .seed(seed),
      .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
      .lockup_err(lockup_err4), .word_cnt(word_cnt4)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (u_dut.state_q === 15'h7FFF) lockup_hits <= lockup_hits + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; out_ready = 1'b0; seed_ld = 1'b0;
      tick(); tick();
      rst = 1'b0;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else pass_cnt++;
      total_cnt++; if (out_data !== 4'h0) $display("FAIL reset_data got %h want 0", out_data); else pass_cnt++;
      total_cnt++; if (word_cnt !== 16'd0) $display("FAIL reset_cnt got %0d want 0", word_cnt); else pass_cnt++;
      total_cnt++; if (lockup_err !== 1'b0) $display("FAIL reset_lockup got %b want 0", lockup_err); else pass_cnt++;
      total_cnt++; if (u_dut.state_q !== 15'h0000) $display("FAIL reset_state got %h want 0000", u_dut.state_q); else pass_cnt++;
   endtask

   task automatic test_stream();
      logic [3:0] exp_w [4] = '{4'b1111, 4'b1111, 4'b1111, 4'b1101};
      en = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         total_cnt++;
         if (out_valid !== 1'b1 || out_data !== exp_w[i])
            $display("FAIL stream_word%0d got v=%b d=%b want v=1 d=%b", i + 1, out_valid, out_data, exp_w[i]);
         else pass_cnt++;
      end
      en = 1'b0;
      tick();
      total_cnt++; if (word_cnt !== 16'd4) $display("FAIL stream_cnt got %0d want 4", word_cnt); else pass_cnt++;
      total_cnt++; if (word_cnt4 !== 4'd4) $display("FAIL stream_cnt4 got %0d want 4", word_cnt4); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL stream_drain_valid got %b want 0", out_valid); else pass_cnt++;
   endtask

   task automatic test_stall();
      logic [3:0] exp_w [4] = '{4'b1111, 4'b1111, 4'b1111, 4'b0011};
      rst = 1'b1; tick(); rst = 1'b0;
      en = 1'b1; out_ready = 1'b1;
      tick(); tick(); tick(); tick();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         total_cnt++;
         if (out_valid !== 1'b1 || out_data !== 4'b1101 || u_dut.state_q !== 15'h7FFD || word_cnt !== 16'd3)
            $display("FAIL stall_hold%0d got v=%b d=%b s=%h c=%0d want v=1 d=1101 s=7ffd c=3",
                     i, out_valid, out_data, u_dut.state_q, word_cnt);
         else pass_cnt++;
      end
      out_ready = 1'b1; en = 1'b0;
      tick();
      total_cnt++;
      if (word_cnt !== 16'd4 || out_valid !== 1'b0)
         $display("FAIL stall_release got c=%0d v=%b want c=4 v=0", word_cnt, out_valid);
      else pass_cnt++;
      en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         total_cnt++;
         if (out_valid !== 1'b1 || out_data !== exp_w[i])
            $display("FAIL stall_resume%0d got v=%b d=%b want v=1 d=%b", i + 5, out_valid, out_data, exp_w[i]);
         else pass_cnt++;
      end
      total_cnt++; if (u_dut.state_q !== 15'h7FF3) $display("FAIL stall_state8 got %h want 7ff3", u_dut.state_q); else pass_cnt++;
   endtask

   task automatic test_free_run();
      rst = 1'b1; tick(); rst = 1'b0;
      lockup_hits = 0;
      en = 1'b1; out_ready = 1'b1;
      for (int n = 1; n <= 32771; n++) begin
         tick();
         if (n == 16) begin
            total_cnt++; if (word_cnt4 !== 4'd15) $display("FAIL wrap_pre got %0d want 15", word_cnt4); else pass_cnt++;
         end
         if (n == 17) begin
            total_cnt++; if (word_cnt4 !== 4'd0) $display("FAIL wrap_zero got %0d want 0", word_cnt4); else pass_cnt++;
         end
         if (n == 32768) begin
            total_cnt++;
            if (out_data !== 4'b1111 || word_cnt !== 16'd32767)
               $display("FAIL period_word got d=%b c=%0d want d=1111 c=32767", out_data, word_cnt);
            else pass_cnt++;
         end
         if (n == 32771) begin
            total_cnt++; if (out_data !== 4'b1101) $display("FAIL period_word4 got %b want 1101", out_data); else pass_cnt++;
         end
      end
      total_cnt++; if (lockup_hits !== 0) $display("FAIL no_lockup_state got %0d hits want 0", lockup_hits); else pass_cnt++;
   endtask

   task automatic test_seed_lockup();
      seed_ld = 1'b1; seed = 15'h7FFF;
      tick();
      seed_ld = 1'b0;
      total_cnt++;
      if (u_dut.state_q !== 15'h0000 || lockup_err !== 1'b1 || out_valid !== 1'b0 || word_cnt !== 16'd32771)
         $display("FAIL seed_lockup got s=%h e=%b v=%b c=%0d want s=0000 e=1 v=0 c=32771",
                  u_dut.state_q, lockup_err, out_valid, word_cnt);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (lockup_err !== 1'b0 || out_valid !== 1'b1 || out_data !== 4'b1111 || word_cnt !== 16'd32771)
         $display("FAIL seed_lockup_next got e=%b v=%b d=%b c=%0d want e=0 v=1 d=1111 c=32771",
                  lockup_err, out_valid, out_data, word_cnt);
      else pass_cnt++;
   endtask

   task automatic test_seed_while_stalled();
      out_ready = 1'b0; en = 1'b1;
      seed_ld = 1'b1; seed = 15'h4000;
      tick();
      seed_ld = 1'b0;
      total_cnt++;
      if (u_dut.state_q !== 15'h4000 || out_valid !== 1'b0 || lockup_err !== 1'b0 || word_cnt !== 16'd32771)
         $display("FAIL seed_stall got s=%h v=%b e=%b c=%0d want s=4000 v=0 e=0 c=32771",
                  u_dut.state_q, out_valid, lockup_err, word_cnt);
      else pass_cnt++;
      out_ready = 1'b1;
      tick();
      total_cnt++; if (out_valid !== 1'b1 || out_data !== 4'b0111) $display("FAIL seed_word1 got v=%b d=%b want v=1 d=0111", out_valid, out_data); else pass_cnt++;
      tick();
      total_cnt++; if (out_data !== 4'b1111) $display("FAIL seed_word2 got %b want 1111", out_data); else pass_cnt++;
   endtask

   task automatic test_reset_midstream();
      logic [3:0] exp_w [4] = '{4'b1111, 4'b1111, 4'b1111, 4'b1101};
      out_ready = 1'b0; en = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total_cnt++;
      if (out_valid !== 1'b0 || out_data !== 4'h0 || word_cnt !== 16'd0)
         $display("FAIL rst_mid got v=%b d=%b c=%0d want v=0 d=0000 c=0", out_valid, out_data, word_cnt);
      else pass_cnt++;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         total_cnt++;
         if (out_data !== exp_w[i]) $display("FAIL rst_restart%0d got %b want %b", i + 1, out_data, exp_w[i]);
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_free_run();
      test_seed_lockup();
      test_seed_while_stalled();
      test_reset_midstream();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
